util_io_test_monitor: RTL

- Run controller and result collector directly downstream of the IO loopback tester.
- Drives the tester's `en`/`clr` and consumes its sticky per-channel `state` vector and `state_valid` window pulse.
- Discards start-up windows, counts check windows, records the first failing channel and window, and stops on pass, fail or abort.
- Results are held for register readout; completion raises a one-cycle `irq`.

---
 rtl/util_io_test_pkg.sv | 16 +
 rtl/util_lsb_index.sv | 23 ++
 rtl/util_io_test_monitor.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/util_io_test_pkg.sv
// Shared types and constants for the IO loopback test monitor.
// Holds the run-controller state encoding and the counter widths.
package util_io_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_ARM   = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4
  } mon_state_t;

  localparam int CNT_W  = 32;
  localparam int DISC_W = 8;

endpackage

// File: rtl/util_lsb_index.sv
// Lowest-set-bit priority encoder: index of the lowest set bit plus a found flag.
module util_lsb_index #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 5
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Scanning from the top lets the lowest set bit overwrite any higher one.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/util_io_test_monitor.sv
// Run controller and result collector for the IO loopback tester: drives en/clr,
// discards start-up windows, counts checked windows and records the first failure.
module util_io_test_monitor
  import util_io_test_pkg::*;
#(
  parameter int IO_WIDTH        = 32,
  parameter int DISCARD_WINDOWS = 1,
  parameter int IDX_W           = 5
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic                abort,
  input  logic                stop_on_fail,
  input  logic [CNT_W-1:0]    target_windows,
  input  logic [IO_WIDTH-1:0] state,
  input  logic                state_valid,
  output logic                test_en,
  output logic                test_clr,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                irq,
  output logic [CNT_W-1:0]    window_cnt,
  output logic [CNT_W-1:0]    fail_cnt,
  output logic [IO_WIDTH-1:0] fail_mask,
  output logic [IDX_W-1:0]    first_fail_idx,
  output logic [CNT_W-1:0]    first_fail_window
);

  localparam logic [DISC_W-1:0] DISC_LAST =
    DISC_W'((DISCARD_WINDOWS == 0) ? 0 : DISCARD_WINDOWS - 1);

  mon_state_t cur_st, nxt_st;

  logic [CNT_W-1:0]    target_q;
  logic                stop_q;
  logic                sv_d;
  logic [DISC_W-1:0]   disc_cnt;
  logic [IO_WIDTH-1:0] new_bits;
  logic [IDX_W-1:0]    lsb_idx;
  logic                lsb_found;
  logic [CNT_W-1:0]    win_inc;
  logic                go;
  logic                sample;
  logic                any_fail;
  logic                target_hit;
  logic                run_end;
  logic                disc_last;
  logic                test_en_d, test_clr_d, busy_d, done_d, irq_d;

  util_lsb_index #(
    .WIDTH (IO_WIDTH),
    .IDX_W (IDX_W)
  ) u_lsb (
    .vec   (new_bits),
    .idx   (lsb_idx),
    .found (lsb_found)
  );

  // Abort suppresses both the sample commit and any completion it would cause.
  always_comb begin
    go         = start && !abort;
    sample     = (cur_st == ST_RUN) && sv_d && !abort;
    new_bits   = state & ~fail_mask;
    win_inc    = (window_cnt == '1) ? window_cnt : window_cnt + 1'b1;
    any_fail   = (fail_cnt != '0) || lsb_found;
    target_hit = (target_q != '0) && (win_inc == target_q);
    run_end    = sample && ((stop_q && any_fail) || target_hit);
    disc_last  = (cur_st == ST_ARM) && state_valid && (disc_cnt == DISC_LAST);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cur_st   <= ST_IDLE;
      test_en  <= 1'b0;
      test_clr <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      irq      <= 1'b0;
    end else begin
      cur_st   <= nxt_st;
      test_en  <= test_en_d;
      test_clr <= test_clr_d;
      busy     <= busy_d;
      done     <= done_d;
      irq      <= irq_d;
    end
  end

  always_comb begin
    nxt_st = cur_st;
    case (cur_st)
      ST_IDLE:  if (go) nxt_st = ST_CLEAR;
      ST_CLEAR: begin
        if (abort)                     nxt_st = ST_IDLE;
        else if (DISCARD_WINDOWS == 0) nxt_st = ST_RUN;
        else                           nxt_st = ST_ARM;
      end
      ST_ARM: begin
        if (abort)                                   nxt_st = ST_IDLE;
        else if (DISCARD_WINDOWS == 0 || disc_last)  nxt_st = ST_RUN;
      end
      ST_RUN: begin
        if (abort)        nxt_st = ST_IDLE;
        else if (run_end) nxt_st = ST_DONE;
      end
      ST_DONE:  if (go) nxt_st = ST_CLEAR;
      default:  nxt_st = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change on the transition edge.
  always_comb begin
    busy_d     = (nxt_st == ST_CLEAR) || (nxt_st == ST_ARM) || (nxt_st == ST_RUN);
    test_en_d  = busy_d;
    test_clr_d = (nxt_st == ST_CLEAR) || ((cur_st == ST_ARM) && (nxt_st == ST_RUN));
    done_d     = (nxt_st == ST_DONE);
    irq_d      = done_d && (cur_st != ST_DONE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      target_q          <= '0;
      stop_q            <= 1'b0;
      sv_d              <= 1'b0;
      disc_cnt          <= '0;
      pass              <= 1'b0;
      window_cnt        <= '0;
      fail_cnt          <= '0;
      fail_mask         <= '0;
      first_fail_idx    <= '0;
      first_fail_window <= '0;
    end else begin
      sv_d <= state_valid && (cur_st == ST_RUN);
      if (go && (cur_st == ST_IDLE || cur_st == ST_DONE)) begin
        target_q          <= target_windows;
        stop_q            <= stop_on_fail;
        disc_cnt          <= '0;
        pass              <= 1'b0;
        window_cnt        <= '0;
        fail_cnt          <= '0;
        fail_mask         <= '0;
        first_fail_idx    <= '0;
        first_fail_window <= '0;
      end
      if (cur_st == ST_ARM && state_valid && !abort) begin
        disc_cnt <= disc_cnt + 1'b1;
      end
      if (sample) begin
        window_cnt <= win_inc;
        fail_mask  <= fail_mask | state;
        if (lsb_found && fail_cnt != '1) begin
          fail_cnt <= fail_cnt + 1'b1;
        end
        if (lsb_found && fail_cnt == '0) begin
          first_fail_idx    <= lsb_idx;
          first_fail_window <= win_inc;
        end
      end
      if (run_end) begin
        pass <= target_hit && !any_fail;
      end
    end
  end

endmodule
